// File: rtl/rf_read_arbiter_if.sv
// Register-file read-port bundle: requests, grants, mux select/data, response.
// master = requester/mux side, slave = arbiter side.
interface rf_read_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*5-1:0] addr;
  logic              stall;
  logic [NREQ-1:0]   gnt;
  logic [4:0]        rd_sel;
  logic [DW-1:0]     rd_data;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [DW-1:0]     rsp_data;

  modport master (
    output req, addr, stall, rd_data,
    input  gnt, rd_sel,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, addr, stall, rd_data,
    output gnt, rd_sel,
    output rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one RF read port; ports: clk, reset (async, low), bus (slave).
// Optional macro RF_ARB_PRIO0_EN: requester 0 gets fixed absolute priority.
module rf_read_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  rf_read_arbiter_if.slave   bus
);

  logic [IDW-1:0]  last;
  logic [IDW-1:0]  win;
  logic            found;
  logic            grant;
  logic            upd_last;
  logic [NREQ-1:0] gnt_c;
  logic [4:0]      sel_c;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [DW-1:0]   rsp_data_q;

  // Scan last+1 .. last+NREQ; the IDW-bit add wraps modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
`ifdef RF_ARB_PRIO0_EN
    if (bus.req[0]) begin
      found = 1'b1;
      win   = '0;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        logic [IDW-1:0] idx;
        idx = last + IDW'(k);
        if (!found && idx != '0 && bus.req[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] idx;
      idx = last + IDW'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`endif
  end

  assign grant = found && !bus.stall;

`ifdef RF_ARB_PRIO0_EN
  // Priority grants to requester 0 leave the rotation untouched.
  assign upd_last = grant && (win != '0);
`else
  assign upd_last = grant;
`endif

  always_comb begin
    gnt_c = '0;
    sel_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && win == IDW'(i)) begin
        gnt_c[i] = 1'b1;
        sel_c    = bus.addr[5*i +: 5];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last        <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (upd_last)
        last <= win;
      rsp_valid_q <= grant;
      if (grant) begin
        rsp_id_q   <= win;
        // Register 31 reads as zero regardless of the mux bank.
        rsp_data_q <= (sel_c == 5'd31) ? '0 : bus.rd_data;
      end
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.rd_sel    = sel_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed testbench for rf_read_arbiter.
// Mux bank model: rd_data = rd_sel*10, or 64'hDEAD when dead is set.
module tb_rf_read_arbiter;

  logic clk;
  logic reset;
  logic dead;
  int   total;
  int   bad;

  rf_read_arbiter_if bus ();

  rf_read_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rd_data = dead ? 64'hDEAD
                            : 64'(bus.rd_sel) * 64'd10;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs then settle for 1ns.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input string tag, input logic v,
                     input logic [1:0] id, input logic [63:0] d);
    chk({tag, ".v"}, 64'(bus.rsp_valid), 64'(v));
    chk({tag, ".id"}, 64'(bus.rsp_id), 64'(id));
    chk({tag, ".d"}, bus.rsp_data, d);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    dead      = 1'b0;
    reset     = 1'b0;
    bus.req   = '0;
    bus.stall = 1'b0;
    bus.addr  = {5'd3, 5'd2, 5'd1, 5'd0};
    #2;
    rsp("rst", 1'b0, 2'd0, 64'd0);
    cyc();
    reset = 1'b1;

`ifdef RF_ARB_PRIO0_EN
    bus.req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1 chk("p0", 64'(bus.gnt), 64'b0001);
      cyc();
    end
    bus.req = 4'b1110;
    #1 chk("p1", 64'(bus.gnt), 64'b0010);
    cyc();
    #1 chk("p2", 64'(bus.gnt), 64'b0100);
    cyc();
    #1 chk("p3", 64'(bus.gnt), 64'b1000);
    cyc();
`else
    // Full rotation
    bus.req = 4'b1111;
    #1;
    chk("rr0.g", 64'(bus.gnt), 64'b0001);
    chk("rr0.v", 64'(bus.rsp_valid), 64'd0);
    cyc();
    chk("rr1.g", 64'(bus.gnt), 64'b0010);
    rsp("rr1", 1'b1, 2'd0, 64'd0);
    cyc();
    chk("rr2.g", 64'(bus.gnt), 64'b0100);
    rsp("rr2", 1'b1, 2'd1, 64'd10);
    cyc();
    chk("rr3.g", 64'(bus.gnt), 64'b1000);
    rsp("rr3", 1'b1, 2'd2, 64'd20);
    cyc();
    chk("rr4.g", 64'(bus.gnt), 64'b0001);
    rsp("rr4", 1'b1, 2'd3, 64'd30);
    cyc();

    // Single requester, back to back
    bus.req  = 4'b0100;
    bus.addr = {5'd3, 5'd7, 5'd1, 5'd0};
    #1;
    chk("s0.g", 64'(bus.gnt), 64'b0100);
    chk("s0.sel", 64'(bus.rd_sel), 64'd7);
    rsp("s0", 1'b1, 2'd0, 64'd0);
    for (int i = 1; i < 3; i++) begin
      cyc();
      chk("s.g", 64'(bus.gnt), 64'b0100);
      rsp("s", 1'b1, 2'd2, 64'd70);
    end
    cyc();
    bus.req = '0;
    #1;
    chk("s3.g", 64'(bus.gnt), 64'd0);
    chk("s3.sel", 64'(bus.rd_sel), 64'd0);
    rsp("s3", 1'b1, 2'd2, 64'd70);
    cyc();
    rsp("hold", 1'b0, 2'd2, 64'd70);

    // Zero register
    dead     = 1'b1;
    bus.req  = 4'b0001;
    bus.addr = {5'd3, 5'd2, 5'd1, 5'd31};
    #1;
    chk("z.g", 64'(bus.gnt), 64'b0001);
    chk("z.sel", 64'(bus.rd_sel), 64'd31);
    cyc();
    bus.req = '0;
    dead    = 1'b0;
    bus.addr = {5'd3, 5'd2, 5'd1, 5'd0};
    #1;
    rsp("z", 1'b1, 2'd0, 64'd0);
    cyc();

    // Stall blocks grants
    bus.req   = 4'b1010;
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("st.g", 64'(bus.gnt), 64'd0);
      chk("st.v", 64'(bus.rsp_valid), 64'd0);
      cyc();
    end
    bus.stall = 1'b0;
    #1;
    chk("st1.g", 64'(bus.gnt), 64'b0010);
    cyc();
    chk("st2.g", 64'(bus.gnt), 64'b1000);
    rsp("st2", 1'b1, 2'd1, 64'd10);
    cyc();
    bus.req = 4'b1111;
    #1;
    chk("wrap.g", 64'(bus.gnt), 64'b0001);
    rsp("st3", 1'b1, 2'd3, 64'd30);
    cyc();

    // Reset while a grant is outstanding
    chk("mr.g", 64'(bus.gnt), 64'b0010);
    chk("mr.v1", 64'(bus.rsp_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    rsp("mr", 1'b0, 2'd0, 64'd0);
    cyc();
    reset = 1'b1;
    #1;
    chk("mr.g2", 64'(bus.gnt), 64'b0001);
    chk("mr.v2", 64'(bus.rsp_valid), 64'd0);
    cyc();
    rsp("mr2", 1'b1, 2'd0, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
